mmio_timer: RTL and testbench
=============================

// Module: mmio_timer
// PURPOSE
//  Memory-mapped timer peripheral on the CPU's external data bus, downstream of the CPU MEM stage.
//  Decodes addr/cs/wr_rd/data_bus_write, answers reads on data_bus_read in the same cycle, and raises irq on compare match.
//  Provides a prescaled 32-bit up-counter with compare, in periodic or one-shot mode.
// PARAMETERS
//  BASE        32'h0000_1000  base byte address; 32-byte window, decoded on addr[31:5]
//  PRESCALE_W  16             width of the PRESCALE register and the prescaler counter
// PORTS
//  clk             in   1   single clock; all state on the rising edge
//  rst             in   1   asynchronous, active-high reset
//  addr            in   32  byte address from the CPU MEM stage
//  cs              in   1   1 = external bus access this cycle
//  wr_rd           in   1   1 = write, 0 = read
//  data_bus_write  in   32  write data
//  data_bus_read   out  32  read data, combinational, same cycle
//  irq             out  1   interrupt = STATUS.MATCH & CTRL.IRQ_EN (from registers, no comb path from inputs)
// BEHAVIOUR
//  Select: sel = cs & (addr[31:5] == BASE[31:5]); off = addr[4:2]; addr[1:0] ignored.
//  Register map:
//    0 CTRL     [0]EN, [1]ONESHOT, [2]IRQ_EN; RW
//    1 PRESCALE [PRESCALE_W-1:0]; RW
//    2 COMPARE  [31:0]; RW
//    3 COUNT    [31:0]; RW
//    4 STATUS   [0]MATCH (W1C), [1]RUNNING (RO)
//  Unmapped offsets and unselected cycles: reads 0, writes ignored.
//  Read data is valid in the cycle sel & !wr_rd is high. Writes take effect at the next rising edge.
//  Reset: all registers 0, FSM IDLE, prescaler 0, irq 0, data_bus_read 0.
//  FSM (IDLE, RUN, DONE):
//    - any state: CTRL write with EN=1 -> RUN next cycle; prescaler cleared.
//      From DONE, COUNT is also cleared to 0. From IDLE/RUN, COUNT is kept.
//    - any state: CTRL write with EN=0 -> IDLE; COUNT holds.
//  Tick: in RUN, the prescaler counts 0..PRESCALE, then wraps to 0 and asserts tick for one cycle.
//    Period = PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
//  On tick:
//    - COUNT != COMPARE: COUNT <= COUNT+1; 32'hFFFF_FFFF wraps to 0.
//    - COUNT == COMPARE: MATCH <= 1, and
//        periodic: COUNT <= 0, stay RUN;
//        one-shot: COUNT holds, CTRL.EN <= 0, -> DONE.
//    Match period = (COMPARE+1)*(PRESCALE+1) cycles.
//  RUNNING = (state == RUN).
//  Simultaneous events:
//    - CPU write to COUNT on a tick cycle: CPU value wins, no increment.
//    - MATCH set and W1C in the same cycle: set wins.
//    - CTRL write and match in the same cycle: CTRL write decides state/EN; MATCH still sets.
//  Writing PRESCALE in RUN does not clear the prescaler.
//    If the prescaler is already above the new value, it wraps on the next cycle (tick asserted).
//  Reset mid-count returns everything to reset values immediately (async); irq drops without a clock.
// STRUCTURE
//  Shared include timer_defs.vh: register offsets, CTRL/STATUS bit positions, FSM state encoding.
//  One sub-module: tick_gen (prescaler counter, clear input, PRESCALE input, tick output).
//  Top level holds decode, register file, FSM and read mux.
// TESTING
//  1 Reset: assert rst mid-count with MATCH=1, IRQ_EN=1 -> irq=0 immediately; all regs read 0 after release.
//  2 Periodic: PRESCALE=1, COMPARE=3, CTRL=5 -> MATCH/irq rise 8 cycles after the first RUN cycle;
//    COUNT reads 0 afterwards; repeats every 8 cycles.
//  3 One-shot: PRESCALE=0, COMPARE=2, CTRL=7 -> match after 3 cycles; CTRL.EN reads 0, RUNNING=0,
//    COUNT stays 2. Rewriting CTRL=7 restarts from COUNT=0.
//  4 Collisions:
//    - write COUNT=100 on a tick cycle -> reads 100 next cycle;
//    - W1C STATUS on a match cycle -> MATCH stays 1.
//  5 Wrap: COUNT=32'hFFFF_FFFE, COMPARE=5, PRESCALE=0 -> reads FFFFFFFF, 0, 1, ... ; MATCH at COUNT=5.
//  6 Decode: cs=0 or addr=BASE+32 write -> no register change; read of offset 5 -> 0;
//    read at BASE+0xC+2 returns COUNT.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, CTRL/STATUS
// bit positions and the FSM state encoding.
package mmio_timer_pkg;

  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_COUNT    = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_MATCH   = 0;
  localparam int STAT_RUNNING = 1;

  // Field order mirrors the CTRL bit positions so a 3-bit slice casts directly.
  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic en;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mmio_timer_tick.sv
// Prescaler for the timer: counts 0..prescale while running and emits a
// one-cycle tick on the wrap, giving a tick period of prescale+1 cycles.
module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  // ">=" rather than "==" so a PRESCALE lowered below the current count wraps
  // on the very next cycle instead of running all the way around.
  assign tick = run & (cnt_q >= prescale);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: bus decode, register file, IDLE/RUN/DONE FSM and
// same-cycle read mux. Compare match sets STATUS.MATCH and drives irq.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_1000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        irq
);

  logic                  sel;
  logic [2:0]            off;
  logic                  wr_en;
  logic                  rd_en;
  logic                  wr_ctrl;
  logic                  wr_prescale;
  logic                  wr_compare;
  logic                  wr_count;
  logic                  wr_status;
  logic                  unused_addr;

  ctrl_t                 ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [31:0]           compare_q;
  logic [31:0]           count_q;
  logic                  match_q;

  state_t                state_q;
  state_t                state_d;
  logic                  running;
  logic                  tick;
  logic                  match_hit;
  logic                  start;
  logic [31:0]           rdata;

  assign sel         = cs & (addr[31:5] == BASE[31:5]);
  assign off         = addr[4:2];
  assign unused_addr = ^addr[1:0];
  assign wr_en       = sel & wr_rd;
  assign rd_en       = sel & ~wr_rd;

  assign wr_ctrl     = wr_en & (off == OFF_CTRL);
  assign wr_prescale = wr_en & (off == OFF_PRESCALE);
  assign wr_compare  = wr_en & (off == OFF_COMPARE);
  assign wr_count    = wr_en & (off == OFF_COUNT);
  assign wr_status   = wr_en & (off == OFF_STATUS);

  assign start     = wr_ctrl & data_bus_write[CTRL_EN];
  assign match_hit = tick & (count_q == compare_q);

  tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clear    (start),
    .run      (running),
    .prescale (prescale_q),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A CTRL write always decides the next state, even against a one-shot match.
  always_comb begin
    state_d = state_q;
    if (wr_ctrl) begin
      state_d = data_bus_write[CTRL_EN] ? ST_RUN : ST_IDLE;
    end else if (match_hit && ctrl_q.oneshot) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    running = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      compare_q  <= '0;
      match_q    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= ctrl_t'(data_bus_write[2:0]);
      end else if (match_hit && ctrl_q.oneshot) begin
        ctrl_q.en <= 1'b0;
      end
      if (wr_prescale) begin
        prescale_q <= data_bus_write[PRESCALE_W-1:0];
      end
      if (wr_compare) begin
        compare_q <= data_bus_write;
      end
      // Hardware set beats a W1C landing in the same cycle.
      if (match_hit) begin
        match_q <= 1'b1;
      end else if (wr_status && data_bus_write[STAT_MATCH]) begin
        match_q <= 1'b0;
      end
    end
  end

  // Priority: CPU COUNT write, then CTRL write (clears only when restarting
  // from DONE, otherwise holds), then the tick-driven update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (wr_count) begin
      count_q <= data_bus_write;
    end else if (wr_ctrl) begin
      if (start && state_q == ST_DONE) begin
        count_q <= '0;
      end
    end else if (tick) begin
      if (!match_hit) begin
        count_q <= count_q + 32'd1;
      end else if (!ctrl_q.oneshot) begin
        count_q <= '0;
      end
    end
  end

  // NOTE: rdata gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:     rdata = {29'd0, ctrl_q};
      OFF_PRESCALE: rdata = 32'(prescale_q);
      OFF_COMPARE:  rdata = compare_q;
      OFF_COUNT:    rdata = count_q;
      OFF_STATUS:   rdata = {30'd0, running, match_q};
      default:      rdata = '0;
    endcase
  end

  assign data_bus_read = rd_en ? rdata : 32'd0;
  assign irq           = match_q & ctrl_q.irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: expected values are queued as stimulus is
// issued and popped when the corresponding DUT output is sampled.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRE  = BASE + 32'h04;
  localparam logic [31:0] A_CMP  = BASE + 32'h08;
  localparam logic [31:0] A_CNT  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        wr_rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data_bus_write = '0;
  logic [31:0] data_bus_read;
  logic        irq;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;

  mmio_timer #(.BASE(BASE), .PRESCALE_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .addr           (addr),
    .cs             (cs),
    .wr_rd          (wr_rd),
    .data_bus_write (data_bus_write),
    .data_bus_read  (data_bus_read),
    .irq            (irq)
  );

  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: observed %h expected queued value", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Drives one bus write cycle; returns at the negedge after the write edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input logic cs_v = 1'b1);
    @(negedge clk);
    cs = cs_v;
    wr_rd = 1'b1;
    addr = a;
    data_bus_write = d;
    @(negedge clk);
    cs = 1'b0;
    wr_rd = 1'b0;
  endtask

  // Combinational read inside the current low clock phase.
  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    push_exp(tag, exp);
    cs = 1'b1;
    wr_rd = 1'b0;
    addr = a;
    #1;
    d = data_bus_read;
    cs = 1'b0;
    check(d);
  endtask

  task automatic irq_chk(input string tag, input logic exp);
    push_exp(tag, {31'd0, exp});
    check({31'd0, irq});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset values
    read_chk("rst_ctrl", A_CTRL, 32'h0);
    read_chk("rst_pre",  A_PRE,  32'h0);
    read_chk("rst_cmp",  A_CMP,  32'h0);
    read_chk("rst_cnt",  A_CNT,  32'h0);
    read_chk("rst_stat", A_STAT, 32'h0);
    irq_chk("rst_irq", 1'b0);

    bus_write(A_PRE, 32'hFFFF_FFFF);
    read_chk("pre_width", A_PRE, 32'h0000_FFFF);

    // Periodic: PRESCALE=1, COMPARE=3, irq enabled
    bus_write(A_PRE, 32'd1);
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'd5);
    read_chk("per_c0_stat", A_STAT, 32'h2);
    read_chk("per_c0_cnt",  A_CNT,  32'h0);
    repeat (7) @(negedge clk);
    read_chk("per_c7_stat", A_STAT, 32'h2);
    read_chk("per_c7_cnt",  A_CNT,  32'h3);
    irq_chk("per_c7_irq", 1'b0);
    @(negedge clk);
    read_chk("per_c8_stat", A_STAT, 32'h3);
    read_chk("per_c8_cnt",  A_CNT,  32'h0);
    irq_chk("per_c8_irq", 1'b1);
    bus_write(A_STAT, 32'h1);
    read_chk("per_w1c_stat", A_STAT, 32'h2);
    read_chk("per_c10_cnt",  A_CNT,  32'h1);
    irq_chk("per_w1c_irq", 1'b0);
    repeat (5) @(negedge clk);
    read_chk("per_c15_stat", A_STAT, 32'h2);
    @(negedge clk);
    read_chk("per_c16_stat", A_STAT, 32'h3);
    irq_chk("per_c16_irq", 1'b1);

    // Asynchronous reset mid-count with irq high
    #3;
    rst = 1'b1;
    #1;
    irq_chk("rst_async_irq", 1'b0);
    @(negedge clk);
    rst = 1'b0;
    read_chk("rst2_ctrl", A_CTRL, 32'h0);
    read_chk("rst2_pre",  A_PRE,  32'h0);
    read_chk("rst2_cmp",  A_CMP,  32'h0);
    read_chk("rst2_cnt",  A_CNT,  32'h0);
    read_chk("rst2_stat", A_STAT, 32'h0);

    // One-shot: PRESCALE=0, COMPARE=2
    bus_write(A_CMP, 32'd2);
    bus_write(A_CTRL, 32'd7);
    repeat (2) @(negedge clk);
    read_chk("os_c2_stat", A_STAT, 32'h2);
    read_chk("os_c2_cnt",  A_CNT,  32'h2);
    @(negedge clk);
    read_chk("os_c3_stat", A_STAT, 32'h1);
    read_chk("os_c3_ctrl", A_CTRL, 32'h6);
    read_chk("os_c3_cnt",  A_CNT,  32'h2);
    irq_chk("os_c3_irq", 1'b1);
    repeat (3) @(negedge clk);
    read_chk("os_hold_cnt",  A_CNT,  32'h2);
    read_chk("os_hold_stat", A_STAT, 32'h1);
    bus_write(A_CTRL, 32'd7);
    read_chk("os_restart_cnt",  A_CNT,  32'h0);
    read_chk("os_restart_stat", A_STAT, 32'h3);
    bus_write(A_CTRL, 32'd0);

    // COUNT write on a tick cycle
    bus_write(A_STAT, 32'h1);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CMP, 32'd1000);
    bus_write(A_CTRL, 32'd1);
    bus_write(A_CNT, 32'd100);
    read_chk("col_cnt_write", A_CNT, 32'd100);
    @(negedge clk);
    read_chk("col_cnt_next", A_CNT, 32'd101);

    // W1C landing on a match cycle
    bus_write(A_CTRL, 32'd0);
    bus_write(A_CNT, 32'd0);
    bus_write(A_CMP, 32'd3);
    bus_write(A_CTRL, 32'd1);
    repeat (2) @(negedge clk);
    bus_write(A_STAT, 32'h1);
    read_chk("col_w1c_set_wins", A_STAT, 32'h3);
    read_chk("col_w1c_cnt",      A_CNT,  32'h0);
    bus_write(A_STAT, 32'h1);
    read_chk("col_w1c_clears", A_STAT, 32'h2);
    // CTRL EN=0 write lands on the c7 match cycle
    bus_write(A_CTRL, 32'd0);
    read_chk("col_ctrl_vs_match_stat", A_STAT, 32'h1);
    read_chk("col_ctrl_vs_match_ctrl", A_CTRL, 32'h0);

    // COUNT wrap through 0xFFFF_FFFF
    bus_write(A_STAT, 32'h1);
    bus_write(A_CNT, 32'hFFFF_FFFE);
    bus_write(A_CMP, 32'd5);
    bus_write(A_CTRL, 32'd1);
    read_chk("wrap_c0", A_CNT, 32'hFFFF_FFFE);
    @(negedge clk);
    read_chk("wrap_c1", A_CNT, 32'hFFFF_FFFF);
    @(negedge clk);
    read_chk("wrap_c2", A_CNT, 32'h0);
    @(negedge clk);
    read_chk("wrap_c3", A_CNT, 32'h1);
    repeat (4) @(negedge clk);
    read_chk("wrap_c7_cnt",  A_CNT,  32'h5);
    read_chk("wrap_c7_stat", A_STAT, 32'h2);
    @(negedge clk);
    read_chk("wrap_c8_stat", A_STAT, 32'h3);
    read_chk("wrap_c8_cnt",  A_CNT,  32'h0);

    // Address decode
    bus_write(A_CTRL, 32'd0);
    bus_write(A_CNT, 32'h1234_5678);
    bus_write(A_CNT, 32'h0000_DEAD, 1'b0);
    read_chk("dec_cs0_write", A_CNT, 32'h1234_5678);
    bus_write(BASE + 32'h2C, 32'h0000_BEEF);
    read_chk("dec_outside_write", A_CNT, 32'h1234_5678);
    bus_write(BASE + 32'h14, 32'hFFFF_FFFF);
    read_chk("dec_off5_ctrl", A_CTRL, 32'h0);
    read_chk("dec_off5_pre",  A_PRE,  32'h0);
    read_chk("dec_off5_cmp",  A_CMP,  32'h5);
    read_chk("dec_off5_read", BASE + 32'h14, 32'h0);
    read_chk("dec_byte_addr", BASE + 32'h0E, 32'h1234_5678);
    read_chk("dec_outside_read", BASE + 32'h2C, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
